// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input,
// derives a duty fraction with a bit-serial divider, and flags stuck inputs.
module pwm_capture #(
    parameter int unsigned Resolution   = 8,
    parameter int unsigned TimeoutTicks = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic                  PWMIn,
    output logic [31:0]           Period,
    output logic [31:0]           HighTime,
    output logic [Resolution-1:0] Duty,
    output logic                  Valid,
    output logic                  Timeout,
    output logic                  Level,
    output logic                  Overrun
);

    localparam int unsigned      StepW    = $clog2(Resolution + 1);
    localparam logic [StepW-1:0] LastStep = StepW'(Resolution);
    localparam logic [31:0]      TmoLast  = 32'(TimeoutTicks - 1);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t state;
    state_t state_nx;

    logic sync1;
    logic sync2;
    logic sync3;
    logic rise;
    logic fall;
    logic edge_any;
    logic tmo_hit;
    logic complete;
    logic start_cnt;
    logic hi_run;
    logic lo_run;

    logic [31:0] period_cnt;
    logic [31:0] high_cnt;
    logic [31:0] high_lat;
    logic [31:0] idle_cnt;

    logic                  busy;
    logic                  sat;
    logic [StepW-1:0]      step;
    logic [31:0]           rem;
    logic [31:0]           den;
    logic [31:0]           per_p;
    logic [31:0]           high_p;
    logic [Resolution-1:0] quo;
    logic [32:0]           rem_sh;
    logic                  ge;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign Level    = sync2;
    assign rise     = sync2 & ~sync3;
    assign fall     = ~sync2 & sync3;
    assign edge_any = sync2 ^ sync3;

    // An edge in the same cycle always wins over the idle timeout.
    assign tmo_hit  = (state != IDLE) && !edge_any
                      && (idle_cnt >= TmoLast);

    assign complete  = Enable && (state == LOW) && rise;
    assign start_cnt = rise && ((state == ARM) || (state == LOW));
    assign hi_run    = (state == HIGH) && !tmo_hit;
    assign lo_run    = (state == LOW) && !tmo_hit && !rise;

    assign rem_sh = {rem, 1'b0};
    assign ge     = rem_sh >= {1'b0, den};

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= PWMIn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: the first rise after arming only starts timing.
    always_comb begin
        state_nx = state;
        if (!Enable) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = ARM;
                ARM: begin
                    if (rise)         state_nx = HIGH;
                    else if (tmo_hit) state_nx = ARM;
                end
                HIGH: begin
                    if (fall)         state_nx = LOW;
                    else if (tmo_hit) state_nx = ARM;
                end
                LOW: begin
                    if (rise)         state_nx = HIGH;
                    else if (tmo_hit) state_nx = ARM;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Period, high-time and edge-idle counters plus the timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            high_lat   <= '0;
            idle_cnt   <= '0;
            Timeout    <= 1'b0;
        end else if (!Enable) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            high_lat   <= '0;
            idle_cnt   <= '0;
            Timeout    <= 1'b0;
        end else begin
            if ((state == IDLE) || edge_any || tmo_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= sinc(idle_cnt);
            end

            if (rise) begin
                Timeout <= 1'b0;
            end else if (tmo_hit) begin
                Timeout <= 1'b1;
            end

            unique case (1'b1)
                start_cnt: begin
                    period_cnt <= 32'd1;
                    high_cnt   <= 32'd1;
                end
                tmo_hit: begin
                    period_cnt <= '0;
                    high_cnt   <= '0;
                end
                hi_run: begin
                    period_cnt <= sinc(period_cnt);
                    high_cnt   <= sinc(high_cnt);
                    if (fall) begin
                        high_lat <= high_cnt;
                    end
                end
                lo_run: begin
                    period_cnt <= sinc(period_cnt);
                end
                default: begin
                end
            endcase
        end
    end

    // Restoring divider: one quotient bit per cycle, then publish results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            sat      <= 1'b0;
            step     <= '0;
            rem      <= '0;
            den      <= '0;
            per_p    <= '0;
            high_p   <= '0;
            quo      <= '0;
            Period   <= '0;
            HighTime <= '0;
            Duty     <= '0;
            Valid    <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            Valid <= 1'b0;
            if (!Enable) begin
                busy    <= 1'b0;
                Overrun <= 1'b0;
            end else if (tmo_hit) begin
                busy <= 1'b0;
            end else if (busy) begin
                if (complete) begin
                    Overrun <= 1'b1;
                end
                if (step == LastStep) begin
                    busy     <= 1'b0;
                    Valid    <= 1'b1;
                    Period   <= per_p;
                    HighTime <= high_p;
                    Duty     <= sat ? '1 : quo;
                end else begin
                    step <= step + StepW'(1);
                    rem  <= ge ? 32'(rem_sh - {1'b0, den})
                               : rem_sh[31:0];
                    quo  <= (quo << 1) | Resolution'(ge);
                end
            end else if (complete) begin
                busy   <= 1'b1;
                step   <= '0;
                rem    <= high_lat;
                den    <= period_cnt;
                per_p  <= period_cnt;
                high_p <= high_lat;
                sat    <= high_lat >= period_cnt;
                quo    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of PWM shapes plus
// hand sequences for timeout, enable abort and reset.
module tb_pwm_capture;

    localparam int R = 8;

    logic clk = 1'b0;
    logic reset;
    logic Enable;
    logic PWMIn;

    logic [31:0]  per_a, high_a, per_b, high_b;
    logic [R-1:0] duty_a, duty_b;
    logic valid_a, tmo_a, lvl_a, ovr_a;
    logic valid_b, tmo_b, lvl_b, ovr_b;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    int qa_cyc[$], qa_per[$], qa_high[$], qa_duty[$];
    int qb_cyc[$], qb_per[$], qb_high[$], qb_duty[$];
    int rises[$];

    logic tmo_b_q = 1'b0;
    int   trise_b = -1;
    int   tfall_b = -1;
    logic tlvl_b  = 1'b0;

    typedef struct {
        int per;
        int hi;
        int n;
        int duty;
        int cnt;
        int ovr;
    } vec_t;

    vec_t vecs[8];

    pwm_capture #(.Resolution(R), .TimeoutTicks(1000)) dut_a (
        .clk(clk), .reset(reset), .Enable(Enable), .PWMIn(PWMIn),
        .Period(per_a), .HighTime(high_a), .Duty(duty_a),
        .Valid(valid_a), .Timeout(tmo_a), .Level(lvl_a),
        .Overrun(ovr_a)
    );

    pwm_capture #(.Resolution(R), .TimeoutTicks(50)) dut_b (
        .clk(clk), .reset(reset), .Enable(Enable), .PWMIn(PWMIn),
        .Period(per_b), .HighTime(high_b), .Duty(duty_b),
        .Valid(valid_b), .Timeout(tmo_b), .Level(lvl_b),
        .Overrun(ovr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every Valid pulse and Timeout transitions away from the edge.
    always @(negedge clk) begin
        if (valid_a) begin
            qa_cyc.push_back(cyc);
            qa_per.push_back(int'(per_a));
            qa_high.push_back(int'(high_a));
            qa_duty.push_back(int'(duty_a));
        end
        if (valid_b) begin
            qb_cyc.push_back(cyc);
            qb_per.push_back(int'(per_b));
            qb_high.push_back(int'(high_b));
            qb_duty.push_back(int'(duty_b));
        end
        if (tmo_b && !tmo_b_q) begin
            trise_b = cyc;
            tlvl_b  = lvl_b;
        end
        if (!tmo_b && tmo_b_q) begin
            tfall_b = cyc;
        end
        tmo_b_q = tmo_b;
    end

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        qa_cyc.delete(); qa_per.delete();
        qa_high.delete(); qa_duty.delete();
        qb_cyc.delete(); qb_per.delete();
        qb_high.delete(); qb_duty.delete();
        rises.delete();
    endtask

    // n periods of `per` cycles, high for the first `hi` of each.
    task automatic drive(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < per; i++) begin
                @(posedge clk);
                #1;
                PWMIn = (i < hi);
                if (i == 0) rises.push_back(cyc);
            end
        end
    endtask

    task automatic rearm();
        @(posedge clk);
        #1;
        Enable = 1'b0;
        PWMIn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        Enable = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int p;

        vecs[0] = '{100, 25,  3, 64,  2, 0};
        vecs[1] = '{7,   6,   3, 219, 1, 1};
        vecs[2] = '{256, 255, 3, 255, 2, 0};
        vecs[3] = '{10,  5,   3, 128, 2, 0};
        vecs[4] = '{50,  1,   3, 5,   2, 0};
        vecs[5] = '{200, 199, 3, 254, 2, 0};
        vecs[6] = '{3,   1,   3, 85,  1, 1};
        vecs[7] = '{4,   2,   8, 128, 3, 1};

        reset  = 1'b0;
        Enable = 1'b0;
        PWMIn  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst period", per_a, 0);
        check("rst high", high_a, 0);
        check("rst duty", duty_a, 0);
        check("rst valid", valid_a, 0);
        check("rst timeout", tmo_a, 0);
        check("rst level", lvl_a, 0);
        check("rst overrun", ovr_a, 0);
        check("rst b period", per_b, 0);

        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[v]) begin
            rearm();
            clear_q();
            drive(vecs[v].per, vecs[v].hi, vecs[v].n);
            repeat (30) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d valid count", v),
                  qa_cyc.size(), vecs[v].cnt);
            if (qa_cyc.size() > 0) begin
                check($sformatf("v%0d valid cycle", v),
                      qa_cyc[0], rises[1] + 12);
            end
            foreach (qa_cyc[i]) begin
                check($sformatf("v%0d period %0d", v, i),
                      qa_per[i], vecs[v].per);
                check($sformatf("v%0d high %0d", v, i),
                      qa_high[i], vecs[v].hi);
                check($sformatf("v%0d duty %0d", v, i),
                      qa_duty[i], vecs[v].duty);
            end
            check($sformatf("v%0d overrun", v), ovr_a, vecs[v].ovr);
        end

        // Enable drop mid-divide, then reset in the middle of HIGH.
        rearm();
        clear_q();
        drive(20, 10, 1);
        @(posedge clk);
        #1;
        PWMIn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        Enable = 1'b0;
        PWMIn  = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("abort no valid", qa_cyc.size(), 0);
        check("abort hold period", per_a, 4);
        check("abort hold high", high_a, 2);
        check("abort hold duty", duty_a, 128);
        check("abort overrun clr", ovr_a, 0);

        @(posedge clk);
        #1;
        Enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        PWMIn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid rst period", per_a, 0);
        check("mid rst high", high_a, 0);
        check("mid rst duty", duty_a, 0);
        check("mid rst valid", valid_a, 0);
        check("mid rst timeout", tmo_a, 0);
        check("mid rst level", lvl_a, 0);
        check("mid rst overrun", ovr_a, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        PWMIn = 1'b0;
        clear_q();
        repeat (4) @(posedge clk);
        drive(20, 10, 2);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("post rst count", qa_cyc.size(), 1);
        if (qa_cyc.size() > 0) begin
            check("post rst cycle", qa_cyc[0], rises[1] + 12);
            check("post rst period", qa_per[0], 20);
            check("post rst high", qa_high[0], 10);
            check("post rst duty", qa_duty[0], 128);
        end

        // Stuck-high input on the short-timeout instance.
        rearm();
        clear_q();
        trise_b = -1;
        tfall_b = -1;
        tlvl_b  = 1'b0;
        @(posedge clk);
        #1;
        PWMIn = 1'b1;
        p = cyc;
        repeat (60) @(posedge clk);
        #1;
        PWMIn = 1'b0;
        repeat (5) @(posedge clk);
        drive(20, 10, 2);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("timeout set cycle", trise_b, p + 53);
        check("timeout level", tlvl_b, 1);
        check("timeout clear cycle", tfall_b, rises[0] + 3);
        check("timeout valid count", qb_cyc.size(), 1);
        if (qb_cyc.size() > 0) begin
            check("timeout valid cycle", qb_cyc[0], rises[1] + 12);
            check("timeout period", qb_per[0], 20);
            check("timeout high", qb_high[0], 10);
            check("timeout duty", qb_duty[0], 128);
        end
        check("timeout now clear", tmo_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
